// File: rtl/block_fall_tracker_if.sv
// Bus between the block scheduler/player logic and the falling-block tracker.
// The master drives release/tick/hit controls; the slave reports block positions and tallies.
interface block_fall_tracker_if #(
    parameter int unsigned NUM_BLOCKS = 10
);
    logic       frame_tick;
    logic       level_two;
    logic       block_ready  [0:NUM_BLOCKS-1];
    logic       hit          [0:NUM_BLOCKS-1];
    logic       block_active [0:NUM_BLOCKS-1];
    logic [8:0] block_y      [0:NUM_BLOCKS-1];
    logic       end_level;
    logic [3:0] hits;
    logic [3:0] misses;

    modport master (
        output frame_tick, level_two, block_ready, hit,
        input  block_active, block_y, end_level, hits, misses
    );

    modport slave (
        input  frame_tick, level_two, block_ready, hit,
        output block_active, block_y, end_level, hits, misses
    );
endinterface

// File: rtl/block_fall_tracker.sv
// Tracks NUM_BLOCKS independently falling blocks: release on block_ready rising edge,
// advance per frame_tick, retire by player hit or by reaching the bottom row.
module block_fall_tracker #(
    parameter int unsigned NUM_BLOCKS = 10,
    parameter logic [8:0]  Y_MAX      = 9'd479,
    parameter int unsigned STEP_L1    = 2,
    parameter int unsigned STEP_L2    = 4
) (
    input logic                Clk,
    input logic                Reset,
    block_fall_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FALLING = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [9:0] STEP_ONE = 10'(STEP_L1);
    localparam logic [9:0] STEP_TWO = 10'(STEP_L2);
    localparam logic [7:0] SAT_WIDE = 8'(NUM_BLOCKS);
    localparam logic [3:0] SAT_CNT  = 4'(NUM_BLOCKS);

    state_t                  state [NUM_BLOCKS];
    logic [8:0]              y_q   [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]   prev;
    logic [3:0]              hits_q;
    logic [3:0]              misses_q;
    logic                    end_q;

    logic [9:0]              step;
    logic [NUM_BLOCKS-1:0]   rel;
    logic [NUM_BLOCKS-1:0]   hit_ret;
    logic [NUM_BLOCKS-1:0]   bot_ret;
    logic [NUM_BLOCKS-1:0]   done_vec;
    logic [7:0]              hit_cnt;
    logic [7:0]              miss_cnt;
    logic [7:0]              hits_sum;
    logic [7:0]              misses_sum;
    logic [3:0]              hits_nxt;
    logic [3:0]              misses_nxt;

    // Hit takes priority over the bottom condition, so bot_ret is masked by hit.
    always_comb begin
        step     = bus.level_two ? STEP_TWO : STEP_ONE;
        rel      = '0;
        hit_ret  = '0;
        bot_ret  = '0;
        done_vec = '0;
        hit_cnt  = '0;
        miss_cnt = '0;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            rel[i]      = bus.block_ready[i] & ~prev[i];
            done_vec[i] = (state[i] == DONE);
            if (state[i] == FALLING) begin
                hit_ret[i] = bus.hit[i];
                bot_ret[i] = ~bus.hit[i] & bus.frame_tick &
                             (({1'b0, y_q[i]} + step) >= {1'b0, Y_MAX});
            end
            hit_cnt  = hit_cnt  + 8'(hit_ret[i]);
            miss_cnt = miss_cnt + 8'(bot_ret[i]);
        end
        hits_sum   = {4'b0, hits_q}   + hit_cnt;
        misses_sum = {4'b0, misses_q} + miss_cnt;
        hits_nxt   = (hits_sum   > SAT_WIDE) ? SAT_CNT : hits_sum[3:0];
        misses_nxt = (misses_sum > SAT_WIDE) ? SAT_CNT : misses_sum[3:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                state[i] <= IDLE;
                y_q[i]   <= '0;
            end
            prev     <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            end_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                prev[i] <= bus.block_ready[i];
                case (state[i])
                    IDLE: begin
                        if (rel[i]) begin
                            state[i] <= FALLING;
                            y_q[i]   <= '0;
                        end
                    end
                    FALLING: begin
                        if (hit_ret[i]) begin
                            state[i] <= DONE;
                        end else if (bot_ret[i]) begin
                            state[i] <= DONE;
                            y_q[i]   <= Y_MAX;
                        end else if (bus.frame_tick) begin
                            y_q[i]   <= y_q[i] + step[8:0];
                        end
                    end
                    DONE: begin
                        if (!bus.block_ready[i]) begin
                            state[i] <= IDLE;
                            y_q[i]   <= '0;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        y_q[i]   <= '0;
                    end
                endcase
            end
            hits_q   <= hits_nxt;
            misses_q <= misses_nxt;
            end_q    <= &done_vec;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            bus.block_active[i] = (state[i] == FALLING);
            bus.block_y[i]      = y_q[i];
        end
        bus.end_level = end_q;
        bus.hits      = hits_q;
        bus.misses    = misses_q;
    end
endmodule

// File: tb/tb_block_fall_tracker.sv
// Scoreboard bench for block_fall_tracker: expectations queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_block_fall_tracker;
    localparam int unsigned NB = 10;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    block_fall_tracker_if #(.NUM_BLOCKS(NB)) bus ();

    block_fall_tracker #(
        .NUM_BLOCKS(NB),
        .Y_MAX(9'd479),
        .STEP_L1(2),
        .STEP_L2(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frames(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic set_ready_all(input logic v);
        for (int i = 0; i < NB; i++) bus.block_ready[i] = v;
    endtask

    task automatic set_hit_all(input logic v);
        for (int i = 0; i < NB; i++) bus.hit[i] = v;
    endtask

    task automatic reset_pulse();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        Reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.level_two  = 1'b0;
        set_ready_all(1'b0);
        set_hit_all(1'b0);

        // Reset state
        sb_push("rst_hits", 0);
        sb_push("rst_misses", 0);
        sb_push("rst_end", 0);
        sb_push("rst_y0", 0);
        sb_push("rst_act0", 0);
        step();
        step();
        sb_pop(bus.hits);
        sb_pop(bus.misses);
        sb_pop(bus.end_level);
        sb_pop(bus.block_y[0]);
        sb_pop(bus.block_active[0]);
        Reset = 1'b0;
        step();

        // Block 0 falls all the way at level one
        sb_push("a_rel_y0", 0);
        sb_push("a_rel_act0", 1);
        bus.block_ready[0] = 1'b1;
        step();
        sb_pop(bus.block_y[0]);
        sb_pop(bus.block_active[0]);

        sb_push("a_t239_y0", 478);
        sb_push("a_t239_act0", 1);
        sb_push("a_t239_misses", 0);
        frames(239);
        sb_pop(bus.block_y[0]);
        sb_pop(bus.block_active[0]);
        sb_pop(bus.misses);

        sb_push("a_t240_y0", 479);
        sb_push("a_t240_act0", 0);
        sb_push("a_t240_misses", 1);
        sb_push("a_t240_hits", 0);
        sb_push("a_t240_end", 0);
        frames(1);
        sb_pop(bus.block_y[0]);
        sb_pop(bus.block_active[0]);
        sb_pop(bus.misses);
        sb_pop(bus.hits);
        sb_pop(bus.end_level);

        sb_push("a_level_high_no_rerelease", 0);
        repeat (3) step();
        sb_pop(bus.block_active[0]);

        sb_push("a_idle_y0", 0);
        bus.block_ready[0] = 1'b0;
        step();
        sb_pop(bus.block_y[0]);

        // Block 3 at level two: hit and bottom in the same cycle
        bus.level_two = 1'b1;
        bus.block_ready[3] = 1'b1;
        step();
        sb_push("c_y3_476", 476);
        frames(119);
        sb_pop(bus.block_y[3]);

        sb_push("c_hitwin_y3", 476);
        sb_push("c_hitwin_act3", 0);
        sb_push("c_hitwin_hits", 1);
        sb_push("c_hitwin_misses", 1);
        bus.frame_tick = 1'b1;
        bus.hit[3]     = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        sb_pop(bus.block_y[3]);
        sb_pop(bus.block_active[3]);
        sb_pop(bus.hits);
        sb_pop(bus.misses);

        sb_push("c_hit_in_done_ignored", 1);
        step();
        sb_pop(bus.hits);
        sb_push("c_hit_in_idle_ignored", 1);
        sb_push("c_idle_y3", 0);
        bus.block_ready[3] = 1'b0;
        step();
        step();
        sb_pop(bus.hits);
        sb_pop(bus.block_y[3]);
        bus.hit[3]    = 1'b0;
        bus.level_two = 1'b0;

        // Block 1 mid-fall, asynchronous reset, re-release with ready held
        bus.block_ready[1] = 1'b1;
        step();
        frames(50);
        sb_push("d_y1_100", 100);
        sb_push("d_freeze_y1", 100);
        sb_pop(bus.block_y[1]);
        repeat (3) step();
        sb_pop(bus.block_y[1]);

        sb_push("d_async_y1", 0);
        sb_push("d_async_act1", 0);
        sb_push("d_async_hits", 0);
        sb_push("d_async_misses", 0);
        sb_push("d_async_end", 0);
        #2;
        Reset = 1'b1;
        #1;
        sb_pop(bus.block_y[1]);
        sb_pop(bus.block_active[1]);
        sb_pop(bus.hits);
        sb_pop(bus.misses);
        sb_pop(bus.end_level);
        #2;
        Reset = 1'b0;
        sb_push("d_rerelease_y1", 0);
        sb_push("d_rerelease_act1", 1);
        step();
        sb_pop(bus.block_y[1]);
        sb_pop(bus.block_active[1]);
        bus.block_ready[1] = 1'b0;
        reset_pulse();

        // Ten blocks released in turn, each hit after five ticks
        for (int i = 0; i < NB; i++) begin
            sb_push($sformatf("b_rel_act%0d", i), 1);
            bus.block_ready[i] = 1'b1;
            step();
            sb_pop(bus.block_active[i]);
            frames(5);
            sb_push($sformatf("b_hit_y%0d", i), 10);
            sb_push($sformatf("b_hit_act%0d", i), 0);
            sb_push($sformatf("b_hit_count%0d", i), 32'(i + 1));
            sb_push($sformatf("b_hit_end%0d", i), 0);
            bus.hit[i] = 1'b1;
            step();
            bus.hit[i] = 1'b0;
            sb_pop(bus.block_y[i]);
            sb_pop(bus.block_active[i]);
            sb_pop(bus.hits);
            sb_pop(bus.end_level);
            repeat (3) step();
        end
        // the loop's trailing idle cycles already give the one Clk for end_level
        sb_push("b_end_level", 1);
        sb_push("b_misses", 0);
        sb_pop(bus.end_level);
        sb_pop(bus.misses);

        // All DONE, then ready all-0
        sb_push("e_end_still_one", 1);
        set_ready_all(1'b0);
        step();
        sb_pop(bus.end_level);
        for (int i = 0; i < NB; i++) sb_push($sformatf("e_y%0d", i), 0);
        sb_push("e_end_zero", 0);
        sb_push("e_hits", 10);
        sb_push("e_misses", 0);
        step();
        for (int i = 0; i < NB; i++) sb_pop(bus.block_y[i]);
        sb_pop(bus.end_level);
        sb_pop(bus.hits);
        sb_pop(bus.misses);

        // Simultaneous retirements and saturation
        reset_pulse();
        set_ready_all(1'b1);
        step();
        sb_push("f_multi_hits", 4);
        sb_push("f_multi_misses0", 0);
        for (int i = 0; i < 4; i++) bus.hit[i] = 1'b1;
        step();
        set_hit_all(1'b0);
        sb_pop(bus.hits);
        sb_pop(bus.misses);

        sb_push("f_multi_misses", 6);
        sb_push("f_multi_hits_hold", 4);
        sb_push("f_y4_bottom", 479);
        sb_push("f_y0_held", 0);
        sb_push("f_end_level", 1);
        frames(240);
        sb_pop(bus.misses);
        sb_pop(bus.hits);
        sb_pop(bus.block_y[4]);
        sb_pop(bus.block_y[0]);
        sb_pop(bus.end_level);

        set_ready_all(1'b0);
        step();
        step();
        set_ready_all(1'b1);
        step();
        sb_push("f_sat_hits", 10);
        sb_push("f_sat_misses", 6);
        set_hit_all(1'b1);
        step();
        set_hit_all(1'b0);
        sb_pop(bus.hits);
        sb_pop(bus.misses);

        if (sb.size() != 0) check_eq("sb_leftover", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/block_fall_tracker.md
BLOCK_FALL_TRACKER -- requirements
Module: block_fall_tracker

Interface
REQ-001 Parameters SHALL be:
- NUM_BLOCKS, default 10, number of tracked blocks.
- Y_MAX, default 479, bottom row (9-bit).
- STEP_L1, default 2, rows per frame_tick in level one.
- STEP_L2, default 4, rows per frame_tick when level_two=1.

REQ-002 Ports SHALL be:
- Clk  in  1  system clock; all state on posedge Clk.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-Clk pulse per video frame.
- block_ready  in  unpacked [0:NUM_BLOCKS-1] x 1  per-block release flags from the block scheduler.
- level_two  in  1  selects STEP_L2.
- hit  in  unpacked [0:NUM_BLOCKS-1] x 1  per-block player-collision flag.
- block_active  out  unpacked [0:NUM_BLOCKS-1] x 1  block is falling (drawable).
- block_y  out  unpacked [0:NUM_BLOCKS-1] x 9  current top row of each block.
- end_level  out  1  all blocks retired; feeds the scheduler.
- hits  out  4  blocks retired by hit.
- misses  out  4  blocks retired at the bottom.

REQ-003 There SHALL be one clock (Clk); Reset SHALL be asynchronous and active-high.

Function
REQ-004 Each block SHALL have an independent FSM with states IDLE, FALLING, DONE.
REQ-005 The block SHALL register block_ready[i] each Clk as prev[i]; a release SHALL be block_ready[i]=1 with prev[i]=0.
REQ-006 IDLE->FALLING SHALL occur on a release, setting block_y[i]=0 in the same edge.
- A level-high block_ready[i] with no rising edge SHALL NOT re-release.
REQ-007 FALLING on a frame_tick cycle SHALL advance block_y[i] by step, where step = STEP_L2 if level_two else STEP_L1.
- Step selection SHALL be sampled in the same cycle as frame_tick.
REQ-008 In FALLING, if block_y[i]+step >= Y_MAX on a frame_tick (10-bit compare, no wrap), then:
- block_y[i] SHALL be set to Y_MAX;
- the state SHALL go to DONE;
- misses SHALL increment.
REQ-009 hit[i]=1 in FALLING SHALL move the block to DONE and increment hits; block_y[i] SHALL hold its value.
REQ-010 If hit[i] and the bottom condition occur in the same cycle, the hit SHALL win: hits increments, misses does not, and block_y[i] holds.
REQ-011 hit[i] SHALL be ignored in IDLE and DONE.
REQ-012 DONE->IDLE SHALL occur when block_ready[i]=0; block_y[i] SHALL then be 0.
REQ-013 block_active[i] SHALL be 1 exactly in FALLING (Moore, combinational from state).
REQ-014 Multiple blocks SHALL update in the same cycle.
- hits and misses SHALL each add the number of blocks retiring into them that cycle.
- hits and misses SHALL saturate at NUM_BLOCKS.
REQ-015 end_level SHALL be registered: 1 on the Clk edge after all blocks are in DONE, and 0 on the edge after any block leaves DONE.
REQ-016 hits and misses SHALL clear only on Reset.
REQ-017 frame_tick=0 SHALL freeze all block_y values.

Reset
REQ-018 Asserting Reset at any time, including mid-fall, SHALL immediately force:
- all FSMs to IDLE and prev to 0;
- block_y to 0, block_active to 0;
- end_level, hits and misses to 0.
REQ-019 After Reset deasserts, a block_ready[i] already high SHALL count as a release on the first Clk edge, because prev=0.

Verification
REQ-020 Release block 0, level_two=0, 240 frame_ticks, no hits -> block_y[0] reaches 479 at tick 240, misses=1, block_active[0]=0 on the following cycle.
REQ-021 Release all 10 blocks one second apart, hit each after 5 ticks -> hits=10, misses=0, end_level=1 exactly one Clk after the tenth hit.
REQ-022 Block 3 at y=476, level_two=1, frame_tick and hit[3] in the same cycle -> DONE with y=476, hits+1, misses unchanged.
REQ-023 Block 1 falling at y=100, Reset pulsed asynchronously between edges -> all outputs 0 immediately; block_ready held high re-releases block 1 at y=0 on the first edge after Reset.
REQ-024 All blocks in DONE, then block_ready driven all-0 -> every FSM returns to IDLE, block_y=0, end_level=0 one Clk later, hits and misses unchanged.
